// File: rtl/fall_edge_pattern_gen.sv
// Stimulus source: emits a burst of N high/low periods with programmable phase lengths,
// plus a strobe on each counted falling edge and a completion strobe.
module fall_edge_pattern_gen #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_edges,
  output logic             D_out,
  output logic             fall_pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StFin} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [LEN_W-1:0] h_q, h_d;
  logic [LEN_W-1:0] l_q, l_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [LEN_W-1:0] h_eff, l_eff;
  logic             d_out_d, fall_d, busy_d, done_d;

  // A zero length would give an empty phase; clamp to one cycle.
  assign h_eff = (high_len == '0) ? LEN_W'(1) : high_len;
  assign l_eff = (low_len == '0) ? LEN_W'(1) : low_len;

  // phase_q holds the cycles remaining in the current phase minus one.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    h_d     = h_q;
    l_d     = l_q;
    edge_d  = edge_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_edges != '0) begin
            h_d     = h_eff;
            l_d     = l_eff;
            n_d     = num_edges;
            phase_d = h_eff - LEN_W'(1);
            edge_d  = '0;
            state_d = StHigh;
          end else begin
            state_d = StFin;
          end
        end
      end
      StHigh: begin
        if (abort) begin
          state_d = StIdle;
        end else if (phase_q == '0) begin
          state_d = StLow;
          phase_d = l_q - LEN_W'(1);
          edge_d  = edge_q + CNT_W'(1);
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StLow: begin
        if (abort) begin
          state_d = StIdle;
        end else if (phase_q == '0) begin
          if (edge_q < n_q) begin
            state_d = StHigh;
            phase_d = h_q - LEN_W'(1);
          end else begin
            state_d = StFin;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    d_out_d = (state_d == StHigh);
    busy_d  = (state_d == StHigh) || (state_d == StLow);
    done_d  = (state_d == StFin);
    // Only a counted HIGH->LOW transition strobes; abort paths never do.
    fall_d  = (state_q == StHigh) && (state_d == StLow);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      h_q        <= '0;
      l_q        <= '0;
      edge_q     <= '0;
      n_q        <= '0;
      D_out      <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      h_q        <= h_d;
      l_q        <= l_d;
      edge_q     <= edge_d;
      n_q        <= n_d;
      D_out      <= d_out_d;
      fall_pulse <= fall_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_fall_edge_pattern_gen.sv
// Bench for fall_edge_pattern_gen: a timing-formula model checked every cycle, plus
// directed bursts with hand-computed cycle expectations.
module tb_fall_edge_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] num_edges = '0;
  logic       D_out, fall_pulse, busy, done;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Model: one active burst described by its accept edge and latched fields.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_h = 1;
  int m_l = 1;
  int m_n = 0;

  fall_edge_pattern_gen #(.LEN_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_edges  (num_edges),
    .D_out      (D_out),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic bit in_run(int c);
    int p;
    p = m_h + m_l;
    return m_active && ((c - m_t - 1) < m_n * p);
  endfunction

  // Expected {D_out, fall_pulse, busy, done} in cycle c.
  function automatic logic [3:0] expect_at(int c);
    int p, rel;
    logic [3:0] r;
    r = 4'b0000;
    if (m_active) begin
      p   = m_h + m_l;
      rel = c - m_t - 1;
      if (rel < m_n * p) begin
        r[3] = (rel % p) < m_h;
        r[2] = (rel % p) == m_h;
        r[1] = 1'b1;
      end else if (rel == m_n * p) begin
        r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (!in_run(cyc) || abort) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_t = cyc;
        m_h = (high_len == 0) ? 1 : int'(high_len);
        m_l = (low_len == 0) ? 1 : int'(low_len);
        m_n = int'(num_edges);
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      e = expect_at(cyc);
      n_cmp++;
      if ({D_out, fall_pulse, busy, done} !== e) begin
        n_err++;
        $display("FAIL model cyc=%0d d/fall/busy/done got %b required %b", cyc,
                 {D_out, fall_pulse, busy, done}, e);
      end
    end
  end

  task automatic check(string name, logic got, logic req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %b required %b", name, cyc, got, req);
    end
  endtask

  task automatic go_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Start is sampled at edge c, so the burst's first cycle is c+1.
  task automatic launch(int c, int h, int l, int n);
    go_to(c);
    high_len  = 8'(h);
    low_len   = 8'(l);
    num_edges = 8'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int det_cnt, fp_cnt;
    bit prev;

    go_to(2);
    check("reset_dout", D_out, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    go_to(3);
    rst = 1'b1;

    // Basic burst H=2 L=3 N=2 at T=10.
    launch(10, 2, 3, 2);
    go_to(11); check("basic_rise", D_out, 1'b1); check("basic_busy", busy, 1'b1);
    go_to(13); check("basic_fall1", fall_pulse, 1'b1); check("basic_low", D_out, 1'b0);
    go_to(17); check("basic_high2", D_out, 1'b1);
    go_to(18); check("basic_fall2", fall_pulse, 1'b1);
    go_to(20); check("basic_busy_end", busy, 1'b1);
    go_to(21); check("basic_done", done, 1'b1); check("basic_fin_busy", busy, 1'b0);
    go_to(22); check("basic_done_once", done, 1'b0);

    // Zero lengths clamp to one cycle.
    launch(30, 0, 0, 3);
    go_to(32); check("zero_fall1", fall_pulse, 1'b1);
    go_to(33); check("zero_high2", D_out, 1'b1);
    go_to(36); check("zero_fall3", fall_pulse, 1'b1);
    go_to(37); check("zero_done", done, 1'b1);

    // Zero count goes straight to completion.
    launch(45, 5, 5, 0);
    go_to(46); check("cnt0_done", done, 1'b1); check("cnt0_dout", D_out, 1'b0);
    check("cnt0_busy", busy, 1'b0);

    // Start with new fields during HIGH is ignored.
    launch(50, 2, 3, 2);
    go_to(51);
    high_len = 8'd7; low_len = 8'd9; num_edges = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    go_to(53); check("ign_fall1", fall_pulse, 1'b1);
    go_to(58); check("ign_fall2", fall_pulse, 1'b1);
    go_to(61); check("ign_done", done, 1'b1);

    // Abort in the second HIGH cycle.
    launch(70, 2, 3, 2);
    go_to(72); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_dout", D_out, 1'b0); check("abort_busy", busy, 1'b0);
    check("abort_fall", fall_pulse, 1'b0);
    go_to(81); check("abort_no_done", done, 1'b0);

    // Reset in the same spot.
    launch(90, 2, 3, 2);
    go_to(92); rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_dout", D_out, 1'b0); check("rst_busy", busy, 1'b0);

    // Abort coinciding with the end of the last LOW beats done.
    launch(100, 1, 1, 2);
    go_to(104); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_no_done", done, 1'b0);

    // Abort during FIN changes nothing.
    launch(110, 1, 1, 1);
    go_to(113); check("fin_done", done, 1'b1); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Back-to-back with start held: FIN at 124, idle at 125, next HIGH at 126.
    go_to(120);
    high_len = 8'd1; low_len = 8'd2; num_edges = 8'd1; start = 1'b1;
    go_to(124); check("b2b_fin", done, 1'b1);
    go_to(125); check("b2b_idle", busy, 1'b0);
    go_to(126); check("b2b_restart", D_out, 1'b1);
    start = 1'b0;

    // Loopback into a bench falling-edge detector.
    launch(140, 1, 1, 5);
    det_cnt = 0; fp_cnt = 0; prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (prev && !D_out) det_cnt++;
      if (fall_pulse) fp_cnt++;
      prev = D_out;
      @(negedge clk);
    end
    n_cmp++;
    if (det_cnt != 5 || fp_cnt != det_cnt) begin
      n_err++;
      $display("FAIL loopback det=%0d fall_pulse=%0d required 5 and 5", det_cnt, fp_cnt);
    end

    // Maximum edge count.
    launch(160, 1, 1, 255);
    go_to(670); check("max_n_busy", busy, 1'b1);
    go_to(671); check("max_n_done", done, 1'b1);

    // Maximum high length.
    launch(700, 255, 1, 2);
    go_to(955); check("max_h_high", D_out, 1'b1);
    go_to(956); check("max_h_fall", fall_pulse, 1'b1);
    go_to(1213); check("max_h_done", done, 1'b1);

    go_to(1220);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
